// File: rtl/muldiv_iter_if.sv
// Handshake/result bundle between the EX stage and the shared iterative mul/div unit.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             annul;
  logic             stall_req;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (
    output start, op, src_a, src_b, annul,
    input  stall_req, busy, done, result_hi, result_lo
  );

  modport slave (
    input  start, op, src_a, src_b, annul,
    output stall_req, busy, done, result_hi, result_lo
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) unit for EX.
// Optional MULDIV_EARLY_OUT_EN: zero operands finish one cycle after accept.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_iter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_is_div;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_res_hi;
  logic [WIDTH-1:0]   r_res_lo;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic             w_signed_op;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic             w_div0;
  logic             w_last;

  assign w_signed_op = ~bus.op[0];
  assign w_sa        = w_signed_op & bus.src_a[WIDTH-1];
  assign w_sb        = w_signed_op & bus.src_b[WIDTH-1];
  assign w_mag_a     = neg_if(bus.src_a, w_sa);
  assign w_mag_b     = neg_if(bus.src_b, w_sb);
  assign w_accept    = (r_state == S_IDLE) & bus.start & ~bus.annul;

  // Multiply: r_hi accumulates, r_lo holds the multiplier and collects product bits.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_div0   = (r_b == '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  logic w_zero;
  assign w_zero = bus.op[1] ? (bus.src_b == '0) : ((bus.src_a == '0) | (bus.src_b == '0));
`endif

  assign bus.stall_req = w_accept |
                         (((r_state == S_CALC) | (r_state == S_FIX)) & ~bus.annul);
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result_hi = r_res_hi;
  assign bus.result_lo = r_res_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_is_div <= bus.op[1];
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_a      <= w_mag_a;
            r_b      <= w_mag_b;
            r_hi     <= '0;
            r_lo     <= bus.op[1] ? w_mag_a : w_mag_b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_zero) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_res_hi <= bus.op[1] ? bus.src_a : '0;
              r_res_lo <= bus.op[1] ? '1 : '0;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          if (bus.annul) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_is_div) begin
              r_hi <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
              r_hi <= w_sum[WIDTH:1];
              r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.annul) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            // Divide by zero returns the raw dividend and skips sign correction.
            if (r_is_div && w_div0) begin
              r_res_lo <= '1;
              r_res_hi <= neg_if(r_a, r_sign_a);
            end else if (r_is_div) begin
              r_res_lo <= neg_if(r_lo, r_sign_a ^ r_sign_b);
              r_res_hi <= neg_if(r_hi, r_sign_a);
            end else begin
              {r_res_hi, r_res_lo} <= neg_if2({r_hi, r_lo}, r_sign_a ^ r_sign_b);
            end
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter at WIDTH=32 and WIDTH=8.
module tb_muldiv_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(32)) bus32 ();
  muldiv_iter_if #(.WIDTH(8))  bus8  ();

  muldiv_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  muldiv_iter #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = 34;
`endif

  int checks   = 0;
  int failures = 0;
  logic [63:0] q32 [$];
  logic [15:0] q8  [$];

  function automatic logic [63:0] model32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = $signed(a); sb = $signed(b);
    ua = {32'b0, a}; ub = {32'b0, b};
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          q = longint'(ua / ub); r = longint'(ua % ub);
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push);
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = op; bus32.src_a = a; bus32.src_b = b;
    if (push) q32.push_back(exp);
    #1;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = op; bus8.src_a = a; bus8.src_b = b;
    q8.push_back(exp);
    #1;
  endtask

  task automatic wait_done32(input int maxc, output int lat, output int stall_cnt);
    lat = -1; stall_cnt = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk); bus32.start = 1'b0; #1;
      if (bus32.done) begin lat = c; break; end
      if (bus32.stall_req) stall_cnt++;
    end
  endtask

  task automatic wait_done8(input int maxc, output int lat, output int stall_cnt);
    lat = -1; stall_cnt = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk); bus8.start = 1'b0; #1;
      if (bus8.done) begin lat = c; break; end
      if (bus8.stall_req) stall_cnt++;
    end
  endtask

  task automatic step32(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk); bus32.start = 1'b0; #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus32.busy, bus32.done, bus32.stall_req} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl32 got=%b exp=000", {bus32.busy, bus32.done, bus32.stall_req});
    end
    checks++;
    if ({bus32.result_hi, bus32.result_lo} !== 64'h0) begin
      failures++; $display("FAIL reset_res32 got=%h exp=0", {bus32.result_hi, bus32.result_lo});
    end
    checks++;
    if ({bus8.busy, bus8.done, bus8.result_hi, bus8.result_lo} !== 18'h0) begin
      failures++; $display("FAIL reset_8 got=%h exp=0", {bus8.busy, bus8.done, bus8.result_hi, bus8.result_lo});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_multu_max;
    int lat, sc;
    logic [63:0] e;
    issue32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b1);
    checks++;
    if (bus32.stall_req !== 1'b1) begin failures++; $display("FAIL multu_stall_c0 got=%b exp=1", bus32.stall_req); end
    wait_done32(40, lat, sc);
    checks++;
    if (lat !== 34) begin failures++; $display("FAIL multu_latency got=%0d exp=34", lat); end
    checks++;
    if (sc !== 33) begin failures++; $display("FAIL multu_stall_cycles got=%0d exp=33", sc); end
    checks++;
    if (bus32.stall_req !== 1'b0) begin failures++; $display("FAIL multu_stall_done got=%b exp=0", bus32.stall_req); end
    e = q32.pop_front();
    checks++;
    if ({bus32.result_hi, bus32.result_lo} !== e) begin
      failures++; $display("FAIL multu_result got=%h exp=%h", {bus32.result_hi, bus32.result_lo}, e);
    end
    step32(1);
    checks++;
    if ({bus32.done, bus32.busy} !== 2'b00) begin
      failures++; $display("FAIL multu_done_pulse got=%b exp=00", {bus32.done, bus32.busy});
    end
  endtask

  // Table-driven single operations with fixed expected latency.
  task automatic run_table(input string name, input logic [1:0] ops [4], input logic [31:0] ta [4],
                           input logic [31:0] tb [4], input logic [63:0] te [4], input int tl [4]);
    int lat, sc;
    logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      issue32(ops[i], ta[i], tb[i], te[i], 1'b1);
      wait_done32(40, lat, sc);
      checks++;
      if (lat !== tl[i]) begin failures++; $display("FAIL %s_lat[%0d] got=%0d exp=%0d", name, i, lat, tl[i]); end
      e = q32.pop_front();
      checks++;
      if ({bus32.result_hi, bus32.result_lo} !== e) begin
        failures++; $display("FAIL %s_res[%0d] got=%h exp=%h", name, i, {bus32.result_hi, bus32.result_lo}, e);
      end
    end
  endtask

  task automatic test_mult_div;
    logic [1:0]  ops [4];
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] te [4];
    int          tl [4];
    ops = '{2'b00, 2'b00, 2'b10, 2'b11};
    ta  = '{32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'd100};
    tb  = '{32'd7, 32'hFFFF_FFFB, 32'd2, 32'd7};
    te  = '{{32'hFFFF_FFFF, 32'hFFFF_FFEB}, {32'h0, 32'h19}, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd2, 32'd14}};
    tl  = '{34, 34, 34, 34};
    run_table("muldiv", ops, ta, tb, te, tl);
  endtask

  task automatic test_div_corner;
    logic [1:0]  ops [4];
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] te [4];
    int          tl [4];
    ops = '{2'b11, 2'b10, 2'b10, 2'b11};
    ta  = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
    tb  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd9};
    te  = '{{32'h64, 32'hFFFF_FFFF}, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, {32'h0, 32'h8000_0000}, {32'd5, 32'd0}};
    tl  = '{LAT_ZERO, LAT_ZERO, 34, 34};
    run_table("divcorner", ops, ta, tb, te, tl);
  endtask

  task automatic test_annul;
    int lat, sc, dones;
    logic [63:0] e;
    issue32(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    wait_done32(40, lat, sc);
    e = q32.pop_front();
    checks++;
    if ({bus32.result_hi, bus32.result_lo} !== e) begin
      failures++; $display("FAIL annul_pre got=%h exp=%h", {bus32.result_hi, bus32.result_lo}, e);
    end
    issue32(2'b00, 32'd1234, 32'd5678, 64'h0, 1'b0);
    step32(9);
    @(negedge clk); bus32.annul = 1'b1; #1;
    checks++;
    if (bus32.stall_req !== 1'b0) begin failures++; $display("FAIL annul_stall got=%b exp=0", bus32.stall_req); end
    @(negedge clk); bus32.annul = 1'b0; #1;
    checks++;
    if ({bus32.busy, bus32.done} !== 2'b00) begin
      failures++; $display("FAIL annul_busy got=%b exp=00", {bus32.busy, bus32.done});
    end
    checks++;
    if ({bus32.result_hi, bus32.result_lo} !== {32'd2, 32'd14}) begin
      failures++; $display("FAIL annul_hold got=%h exp=%h", {bus32.result_hi, bus32.result_lo}, {32'd2, 32'd14});
    end
    issue32(2'b11, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b1);
    wait_done32(40, lat, sc);
    checks++;
    if (lat !== 34) begin failures++; $display("FAIL annul_next_lat got=%0d exp=34", lat); end
    e = q32.pop_front();
    checks++;
    if ({bus32.result_hi, bus32.result_lo} !== e) begin
      failures++; $display("FAIL annul_next_res got=%h exp=%h", {bus32.result_hi, bus32.result_lo}, e);
    end
    // start together with annul in IDLE must be ignored
    @(negedge clk); bus32.start = 1'b1; bus32.annul = 1'b1; bus32.op = 2'b01; #1;
    checks++;
    if (bus32.stall_req !== 1'b0) begin failures++; $display("FAIL annul_start_stall got=%b exp=0", bus32.stall_req); end
    @(negedge clk); bus32.start = 1'b0; bus32.annul = 1'b0; #1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus32.busy || bus32.done) dones++;
      step32(1);
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL annul_start_ignored got=%0d exp=0", dones); end
  endtask

  task automatic test_reset_mid;
    issue32(2'b10, 32'hFFFF_FF9C, 32'd7, 64'h0, 1'b0);
    step32(4);
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({bus32.busy, bus32.done, bus32.stall_req} !== 3'b000) begin
      failures++; $display("FAIL rstmid_ctrl got=%b exp=000", {bus32.busy, bus32.done, bus32.stall_req});
    end
    checks++;
    if ({bus32.result_hi, bus32.result_lo} !== 64'h0) begin
      failures++; $display("FAIL rstmid_res got=%h exp=0", {bus32.result_hi, bus32.result_lo});
    end
  endtask

  task automatic test_start_while_busy;
    int lat, sc, dones;
    logic [63:0] e;
    issue32(2'b11, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b1);
    step32(2);
    @(negedge clk); bus32.start = 1'b1; bus32.op = 2'b01; bus32.src_a = 32'd2; bus32.src_b = 32'd2; #1;
    checks++;
    if (bus32.busy !== 1'b1) begin failures++; $display("FAIL busy_calc got=%b exp=1", bus32.busy); end
    wait_done32(40, lat, sc);
    checks++;
    if (lat !== 31) begin failures++; $display("FAIL busy_lat got=%0d exp=31", lat); end
    e = q32.pop_front();
    checks++;
    if ({bus32.result_hi, bus32.result_lo} !== e) begin
      failures++; $display("FAIL busy_res got=%h exp=%h", {bus32.result_hi, bus32.result_lo}, e);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      step32(1);
      if (bus32.done) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL busy_second_done got=%0d exp=0", dones); end
  endtask

  task automatic test_back_to_back;
    int lat, sc;
    logic [63:0] e;
    logic [31:0] a, b;
    logic [1:0]  op;
    for (int i = 0; i < 8; i++) begin
      op = 2'(i);
      a = $urandom(); b = $urandom();
      if (i >= 4) b = b >> ($urandom_range(0, 28));
      if (a == 0) a = 32'd1;
      if (b == 0) b = 32'd1;
      issue32(op, a, b, model32(op, a, b), 1'b1);
      wait_done32(40, lat, sc);
      checks++;
      if (lat !== 34) begin failures++; $display("FAIL b2b_lat[%0d] got=%0d exp=34", i, lat); end
      e = q32.pop_front();
      checks++;
      if ({bus32.result_hi, bus32.result_lo} !== e) begin
        failures++; $display("FAIL b2b_res[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b,
                             {bus32.result_hi, bus32.result_lo}, e);
      end
    end
  endtask

  task automatic test_width8;
    int lat, sc;
    logic [15:0] e;
    logic [1:0]  ops [3];
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic [15:0] te [3];
    ops = '{2'b01, 2'b10, 2'b11};
    ta  = '{8'hFF, 8'hF9, 8'd100};
    tb  = '{8'hFF, 8'd2, 8'd7};
    te  = '{16'hFE01, 16'hFFFD, 16'h020E};
    for (int i = 0; i < 3; i++) begin
      issue8(ops[i], ta[i], tb[i], te[i]);
      checks++;
      if (bus8.stall_req !== 1'b1) begin failures++; $display("FAIL w8_stall_c0[%0d] got=%b exp=1", i, bus8.stall_req); end
      wait_done8(20, lat, sc);
      checks++;
      if (lat !== 10 || sc !== 9) begin
        failures++; $display("FAIL w8_lat[%0d] got=%0d/%0d exp=10/9", i, lat, sc);
      end
      e = q8.pop_front();
      checks++;
      if ({bus8.result_hi, bus8.result_lo} !== e) begin
        failures++; $display("FAIL w8_res[%0d] got=%h exp=%h", i, {bus8.result_hi, bus8.result_lo}, e);
      end
    end
  endtask

  initial begin
    bus32.start = 1'b0; bus32.op = 2'b00; bus32.src_a = '0; bus32.src_b = '0; bus32.annul = 1'b0;
    bus8.start  = 1'b0; bus8.op  = 2'b00; bus8.src_a  = '0; bus8.src_b  = '0; bus8.annul  = 1'b0;
    test_reset;
    test_multu_max;
    test_mult_div;
    test_div_corner;
    test_annul;
    test_reset_mid;
    test_start_while_busy;
    test_back_to_back;
    test_width8;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage.
- Replaces the separate fixed-width mul/div instances with one shared datapath.
- Executes signed and unsigned multiply and divide over multiple cycles, using a start/done handshake.
- Drives a stall request so the pipeline holds EX until the 2×WIDTH-bit {hi, lo} result is ready.

Parameters:
- WIDTH, 32, operand width in bits; result is 2×WIDTH; WIDTH ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src_a  input  WIDTH  multiplicand / dividend.
- src_b  input  WIDTH  multiplier / divisor.
- annul  input  1  flush; aborts the operation in flight.
- stall_req  output  1  hold EX; combinational.
- busy  output  1  registered; high in CALC, FIX and DONE.
- done  output  1  registered; one-cycle pulse, result valid.
- result_hi  output  WIDTH  MULT: product high half; DIV: remainder.
- result_lo  output  WIDTH  MULT: product low half; DIV: quotient.

Behaviour:
- Reset state: IDLE. Outputs: busy=0, done=0, result_hi=0, result_lo=0. Counter, operand registers and sign flags all cleared.
- FSM states: IDLE → CALC → FIX → DONE → IDLE.
- Accept: in IDLE with start=1 and annul=0, latch op, |src_a|, |src_b| and the sign flags, then go to CALC with counter=0.
  - Magnitudes are taken only for signed ops; unsigned ops latch the raw operands.
- CALC, one iteration per cycle:
  - Multiply: shift-add.
  - Divide: radix-2 restoring.
  - Leave CALC after exactly WIDTH iterations (counter reaches WIDTH-1 → FIX).
- FIX: sign correction.
  - Product is negated if sign_a^sign_b.
  - Quotient is negated if sign_a^sign_b; remainder is negated if sign_a.
  - Load result_hi/result_lo; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted in cycle N → done=1 in cycle N+WIDTH+2. Results are written at the FIX→DONE edge.
- Result hold: result_hi/result_lo stay stable from DONE until the next FIX.
- stall_req = (IDLE & start & ~annul) | CALC | FIX.
  - Low in DONE, so EX captures the result in that cycle.
  - Low in IDLE when there is no start.
- Divide by zero, signed or unsigned: result_lo = all ones, result_hi = src_a unmodified. Sign fix is bypassed. Latency is unchanged.
- Overflow case DIV with most-negative / -1: result_lo = most-negative (wraps), result_hi = 0.
- annul in CALC or FIX: next state IDLE, busy=0, no done pulse, result registers unchanged. stall_req drops combinationally in the same cycle.
- annul in DONE: done still completes; the caller discards the result.
- annul with start in IDLE: start is ignored.
- start while busy: ignored. No queueing.
- Reset mid-operation: behaves the same as annul, and the result registers are also cleared.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - An accept with a zero operand (either operand for MULT/MULTU, the divisor for DIV/DIVU) goes straight to DONE on the next edge, skipping CALC and FIX. Latency is 1 cycle.
  - Result for a zero multiply operand: hi=0, lo=0.
  - Result for a zero divisor: the divide-by-zero values above.
  - stall_req is high only in the accept cycle.
- Not defined: every operation takes WIDTH+2 cycles. No zero-detect logic is synthesised.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at cycle 0 → done at cycle 34 with hi=0xFFFFFFFE, lo=0x00000001; stall_req high cycles 0–33, low at 34.
- MULT -3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT -5 × -5 → hi=0, lo=0x00000019.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=0x00000064 at cycle 34 (cycle 1 with MULDIV_EARLY_OUT_EN). DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT started, then annul at cycle 10:
  - Required: stall_req=0 in cycle 10, busy=0 from cycle 11, no done, result regs unchanged.
  - A new DIVU 9/3 started at cycle 12 gives done at cycle 46 with lo=3, hi=0.
- rst asserted at cycle 5 of a DIV → from the next cycle: IDLE, busy=0, done=0, results=0. start pulsed while busy is ignored (no second done).
- Bench runs all scenarios at WIDTH=32, plus scenarios 1 and 3 at WIDTH=8 (latency 10).
